// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the loader state encoding, the word geometry, the header byte order,
// and a small helper that tells which states consume stream bytes.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (enables the StChk state).
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StChk,
    StDone,
    StErr
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Program-length header arrives most significant byte first.
  localparam bit LEN_MSB_FIRST = 1'b1;

  // States in which the loader asserts in_ready.
  function automatic logic takes_bytes(state_e s);
    return (s == StLenHi) || (s == StLenLo) || (s == StData) || (s == StChk);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// Signals:
//   in_data/in_valid/in_ready : byte stream from the host link receiver
//   mem_we/mem_addr/mem_wdata : single write port into the instruction RAM
// Modports:
//   master : environment side (drives the stream, observes the write port)
//   slave  : loader side
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 31
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Word packer: gathers accepted bytes MSB first into 32-bit words.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : drops any partial word and restarts at byte 0
//   accept      : a byte on data is taken this cycle
//   data        : stream byte
//   word_valid  : this accepted byte completes a word (combinational)
//   word        : the completed word, valid together with word_valid
module imem_loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q;
  // Only the three most recent bytes are kept; the fourth is taken straight
  // from data so the word is available in the cycle it completes.
  logic [23:0] sr_q;

  assign word       = {sr_q, data};
  assign word_valid = accept && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (clear) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + 2'd1;
      sr_q  <= word[23:0];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader.
// Receives a big-endian byte stream: a 2-byte program length (in words)
// followed by the program words, packs them into 32-bit words and writes them
// into the instruction RAM. The CPU is held in reset while loading and is
// released only after a complete, accepted image.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse, begins a new load (aborts any load in progress)
//   bus        : byte stream in, memory write port out (imem_loader_if.slave)
//   cpu_hold   : keep CPU in reset
//   done       : load completed successfully
//   err        : load rejected or corrupt
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte after the last program word.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32,
  parameter int unsigned ADDR_W    = 31,
  parameter int unsigned LEN_W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS + 1);

  state_e            state_q, state_d;
  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              cpu_hold_q;
  logic              done_q;
  logic              err_q;
  logic [IDX_W-1:0]  word_idx_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_d;
  logic [7:0]        len_first_q;

  logic              byte_acc;
  logic              data_acc;
  logic              last_word;
  logic              word_valid;
  logic [31:0]       word;

  // start wins over a byte offered in the same cycle: the byte is dropped.
  assign byte_acc  = bus.in_valid && in_ready_q && !start;
  assign data_acc  = byte_acc && (state_q == StData);
  assign len_d     = LEN_MSB_FIRST ? LEN_W'({len_first_q, bus.in_data})
                                   : LEN_W'({bus.in_data, len_first_q});
  assign last_word = (LEN_W'(word_idx_q) == len_q - LEN_W'(1));

  imem_loader_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start),
    .accept     (data_acc),
    .data       (bus.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (start) begin
      csum_q <= '0;
    end else if (data_acc) begin
      csum_q <= csum_q ^ bus.in_data;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StIdle;
      StLenHi: begin
        if (byte_acc) state_d = StLenLo;
      end
      StLenLo: begin
        if (byte_acc) begin
          if (len_d == '0) begin
            state_d = StDone;
          end else if (32'(len_d) > MEM_WORDS) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (word_valid && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = StChk;
`else
          state_d = StDone;
`endif
        end
      end
      StChk: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (byte_acc) state_d = (bus.in_data == csum_q) ? StDone : StErr;
`else
        // Unreachable without the checksum feature.
        state_d = StErr;
`endif
      end
      StDone: state_d = StDone;
      StErr:  state_d = StErr;
      default: state_d = StIdle;
    endcase
    if (start) state_d = StLenHi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      word_idx_q  <= '0;
      len_q       <= '0;
      len_first_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= takes_bytes(state_d);
      // word_valid is already suppressed by start, so an aborted word never writes.
      mem_we_q   <= word_valid;
      if (word_valid) begin
        mem_addr_q  <= ADDR_W'(word_idx_q) << $clog2(BYTES_PER_WORD);
        mem_wdata_q <= word;
      end
      if (start) begin
        word_idx_q <= '0;
        len_q      <= '0;
        done_q     <= 1'b0;
        err_q      <= 1'b0;
        cpu_hold_q <= 1'b1;
      end else begin
        if (word_valid) word_idx_q <= word_idx_q + IDX_W'(1);
        if (byte_acc && (state_q == StLenHi)) len_first_q <= bus.in_data;
        if (byte_acc && (state_q == StLenLo)) len_q <= len_d;
        if (state_d == StDone) begin
          done_q     <= 1'b1;
          cpu_hold_q <= 1'b0;
        end
        if (state_d == StErr) begin
          err_q      <= 1'b1;
          cpu_hold_q <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: randomized and directed loads checked by a
// scoreboard of expected memory writes plus end-of-load status checks.
module tb_imem_loader;

  localparam int unsigned MEM_WORDS = 32;
  localparam int unsigned ADDR_W    = 31;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, done, err;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .MEM_WORDS (MEM_WORDS),
    .ADDR_W    (ADDR_W),
    .LEN_W     (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  payload[$];
  logic        prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_addr.size() == 0) begin
        check("unexpected_write", 32'(bus.mem_we), 32'd0);
      end else begin
        check("write_addr", 32'(bus.mem_addr), exp_addr.pop_front());
        check("write_data", bus.mem_wdata, exp_data.pop_front());
      end
      check("we_single_pulse", 32'(prev_we), 32'd0);
    end
    prev_we = bus.mem_we;
  end

  // Reference model: a program of len words produces writes word w -> addr 4*w,
  // bytes packed big-endian.
  task automatic expect_words(input int n);
    for (int w = 0; w < n; w++) begin
      exp_addr.push_back(32'(4 * w));
      exp_data.push_back({payload[4*w], payload[4*w+1], payload[4*w+2], payload[4*w+3]});
    end
  endtask

  task automatic fill_random(input int len);
    payload.delete();
    for (int i = 0; i < 4 * len; i++) payload.push_back(8'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  tries = 0;
    bit  taken = 0;
    while (!taken) begin
      @(negedge clk);
      bus.in_data  = b;
      bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.in_valid && bus.in_ready) begin
        @(posedge clk);
        taken = 1;
      end else begin
        tries++;
        if (tries > 100) begin
          check("byte_accept_timeout", 32'(bus.in_ready), 32'd1);
          bus.in_valid = 1'b0;
          taken = 1;
        end
      end
    end
  endtask

  task automatic pulse_start(input bit with_byte);
    @(negedge clk);
    start        = 1'b1;
    bus.in_valid = with_byte;
    bus.in_data  = 8'hee;
    @(negedge clk);
    start        = 1'b0;
    bus.in_valid = 1'b0;
    check("hold_after_start", 32'(cpu_hold), 32'd1);
    check("ready_after_start", 32'(bus.in_ready), 32'd1);
    check("done_cleared", 32'(done), 32'd0);
    check("err_cleared", 32'(err), 32'd0);
  endtask

  task automatic finish_load(input bit exp_ok);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!(done || err) && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("done", 32'(done), 32'(exp_ok));
    check("err", 32'(err), 32'(!exp_ok));
    check("cpu_hold", 32'(cpu_hold), 32'(!exp_ok));
    check("in_ready_after_load", 32'(bus.in_ready), 32'd0);
    check("writes_pending", 32'(exp_addr.size()), 32'd0);
  endtask

  // Full load of len words from payload; chk_flip corrupts the checksum byte.
  task automatic run_load(input int len, input bit gaps, input logic [7:0] chk_flip,
                          input bit start_with_byte);
    logic [15:0] l;
    logic [7:0]  x;
    bit          ok;
    l  = 16'(len);
    x  = 8'h00;
    ok = 1'b1;
    pulse_start(start_with_byte);
    send_byte(l[15:8], gaps);
    send_byte(l[7:0], gaps);
    if (len > int'(MEM_WORDS)) begin
      ok = 1'b0;
    end else if (len > 0) begin
      expect_words(len);
      for (int i = 0; i < 4 * len; i++) begin
        send_byte(payload[i], gaps);
        x ^= payload[i];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(x ^ chk_flip, gaps);
      ok = (chk_flip == 8'h00);
`endif
    end
    finish_load(ok);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed three-word program.
    payload = '{8'h3c, 8'h11, 8'h40, 8'h00, 8'h26, 8'h31, 8'h00, 8'h04,
                8'h24, 8'h10, 8'h00, 8'haa};
    run_load(3, 1'b0, 8'h00, 1'b0);

    // Over-length header is rejected before any data.
    run_load(int'(MEM_WORDS) + 1, 1'b0, 8'h00, 1'b0);

    // Empty program finishes right after the header.
    run_load(0, 1'b0, 8'h00, 1'b0);

    // Abort a len=2 load after 5 data bytes, then reload addr 0.
    fill_random(2);
    pulse_start(1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    expect_words(1);
    for (int i = 0; i < 5; i++) send_byte(payload[i], 1'b0);
    payload = '{8'h00, 8'h00, 8'h00, 8'h0c};
    run_load(1, 1'b0, 8'h00, 1'b1);

    // Same len=4 program with a gappy and a continuous stream.
    fill_random(4);
    run_load(4, 1'b1, 8'h00, 1'b0);
    run_load(4, 1'b0, 8'h00, 1'b0);

    // Random programs including the maximum length.
    fill_random(int'(MEM_WORDS));
    run_load(int'(MEM_WORDS), 1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      int len;
      len = int'($urandom_range(1, MEM_WORDS));
      fill_random(len);
      run_load(len, 1'($urandom_range(0, 1)), 8'h00, 1'b0);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    payload = '{8'h02, 8'h74, 8'h88, 8'h25};
    run_load(1, 1'b0, 8'h00, 1'b0);
    // Flip by db turns the correct checksum db into 00.
    run_load(1, 1'b0, 8'hdb, 1'b0);
`endif

    // Reset in the middle of the second word: only the first word is written.
    fill_random(2);
    pulse_start(1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    expect_words(1);
    for (int i = 0; i < 6; i++) send_byte(payload[i], 1'b0);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_reset_values();
    check("rst_writes_pending", 32'(exp_addr.size()), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    fill_random(1);
    run_load(1, 1'b1, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction ROM: takes a big-endian byte stream from the host link, packs it into 32-bit instruction words, and writes them into the instruction RAM via a single write port.
- Holds the CPU in reset while loading, then releases it.
- Sits between the byte-stream receiver and the instruction memory's write port.

Parameters:
- MEM_WORDS, 32, instruction memory depth in words; also the maximum legal program length.
- ADDR_W, 31, width of the byte address presented to memory (matches the CPU instruction-address width).
- LEN_W, 16, width of the program-length header field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a new load and aborts any load in progress.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  one-cycle write strobe.
- mem_addr  output  ADDR_W  byte address; always word aligned, so bits [1:0] are 0.
- mem_wdata  output  32  instruction word.
- cpu_hold  output  1  keep CPU in reset.
- done  output  1  load completed successfully.
- err  output  1  load rejected or corrupt.

Behaviour:
- Byte transfer: a byte is accepted when in_valid && in_ready on a rising edge.
- Reset values: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, err=0. Word index, byte counter and length register are all 0.
- Reset mid-load: immediate return to the reset values. A partial word is discarded and no write is issued.
- IDLE:
  - in_ready=0; done and err hold their last values.
  - start -> LEN_HI; clears done, err, word index and byte count; sets cpu_hold=1.
- LEN_HI: in_ready=1; the accepted byte becomes len[15:8] -> LEN_LO.
- LEN_LO: in_ready=1; the accepted byte becomes len[7:0]. Next state:
  - len==0 -> DONE.
  - len>MEM_WORDS -> ERR.
  - otherwise -> DATA.
- DATA:
  - in_ready=1; bytes are packed MSB first. Bytes 3c,11,40,00 form 32'h3c114000.
  - On the 4th accepted byte of a word, the next cycle has mem_we=1, mem_wdata=the packed word, and mem_addr = word_idx*4.
  - After that write, word_idx increments. When the written word_idx == len-1, go to DONE (or CHK when the optional feature is compiled in).
  - mem_we is a registered single-cycle pulse. Back-to-back words at one byte per cycle give one write every 4 cycles, with no stall.
- DONE: done=1, cpu_hold=0, in_ready=0; stays until start.
- ERR: err=1, cpu_hold=1 (the CPU must not run a partial image), in_ready=0; stays until start.
- start in any state: forces LEN_HI on the next edge with counters cleared. A pending mem_we from the previous cycle still completes; no new writes occur for the aborted word.
- Simultaneous start and byte acceptance: start wins and the byte is dropped.
- Word index: the counter is wide enough for MEM_WORDS. It never wraps, because len<=MEM_WORDS is enforced.
- Bytes offered while in_ready=0 are not consumed. The loader never drops an accepted byte except on start or reset.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - A running XOR of all DATA bytes is kept; it is cleared on start.
  - After the last word the loader enters CHK with in_ready=1 and accepts one checksum byte.
  - Match -> DONE; mismatch -> ERR.
  - The memory has already been written, so on mismatch err=1 and cpu_hold=1.
  - len==0 skips CHK.
- When undefined: no CHK state; the last word goes directly to DONE, and the streamed byte count is exactly 2+4*len.

Decomposition:
- Package imem_loader_pkg holds:
  - the state encoding (IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR);
  - BYTES_PER_WORD=4;
  - the header byte-order constant.
- Sub-module word_packer: 2-bit byte counter plus 32-bit shift register. Shifts left by 8 on each accepted byte, clears on start, and outputs word_valid and word. The FSM, addressing and checksum stay in imem_loader.

Test Plan:
- len=3, then bytes 3c 11 40 00 | 26 31 00 04 | 24 10 00 aa streamed at one per cycle -> three mem_we pulses: addr 0/4/8, data 3c114000/26310004/241000aa; then done=1 and cpu_hold=0.
- len=33 with MEM_WORDS=32 -> err=1 after the 2nd header byte, no mem_we, in_ready=0, cpu_hold=1.
- len=0 -> done=1 immediately after the header, no writes.
- len=2 with start pulsed after 5 data bytes, then a fresh len=1 load of 0000000c -> exactly one write from the aborted load (the first word at addr 0), then addr 0 rewritten with 0000000c; done=1.
- in_valid toggled randomly during len=4 -> writes identical to the continuous-stream case; no byte accepted while in_ready=0.
- IMEM_LOADER_CHECKSUM_EN, len=1, word 0274_8825:
  - correct checksum byte (02^74^88^25=db) -> done=1;
  - checksum byte 00 -> err=1, cpu_hold=1.
